lcd_timing_gen: RTL and testbench
=================================

# lcd_timing_gen

Parametrised LVDS panel timing generator and pixel source, driving the four LVDS transmit lanes from the parallel pixel clock. It generalises fixed-panel colour-bar test logic in four ways:
- All porches and colour depth are parameters, and sync polarities are configurable.
- Four pixel sources are selectable: external stream, colour bars, grid and solid colour.
- A fixed-lead pixel request lets an upstream frame buffer supply pixels.
- It detects and flags upstream underflow.

It sits between the display pipeline and the LVDS serialiser.

## Interface
Parameters:
- H_SYNC, 20: hsync width (clocks)
- H_BACK, 140: horizontal back porch
- H_ACTIVE, 1024: active pixels per line; must be a multiple of 8
- H_FRONT, 160: horizontal front porch
- V_SYNC, 3: vsync width (lines)
- V_BACK, 20: vertical back porch
- V_ACTIVE, 600: active lines
- V_FRONT, 12: vertical front porch
- COLOR_W, 8: bits per colour channel
- HS_POL, 0: active level of hsync
- VS_POL, 0: active level of vsync
- REQ_LEAD, 2: clocks from pix_req to the matching de pixel; range 1..H_SYNC+H_BACK-1

Derived values:
- H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; must be ≤ 4096.
- V_TOTAL is defined likewise; must be ≤ 4096.

Ports (reset is synchronous and active-high):
- lvds_parallel_clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous active-high reset
- mode_in  in  2  0 = external, 1 = colour bars, 2 = grid, 3 = solid
- solid_rgb  in  3*COLOR_W  {R,G,B} for mode 3
- ext_rgb  in  3*COLOR_W  {R,G,B} external pixel
- ext_valid  in  1  ext_rgb valid
- pix_req  out  1  a pixel is requested (lead = REQ_LEAD)
- pix_x  out  12  x coordinate of the requested pixel
- pix_y  out  12  y coordinate of the requested pixel
- frame_start  out  1  one-clock pulse at counter position (0,0)
- underflow  out  1  sticky; ext_valid was low when a pixel was needed
- lvds_tx0_DATA  out  COLOR_W  red
- lvds_tx1_DATA  out  COLOR_W  green
- lvds_tx2_DATA  out  COLOR_W  blue
- lvds_tx3_DATA  out  8  {5'b0, de, hsync, vsync}

## Operation
- Counters h_cnt and v_cnt are 12 bits, free-running.
  - h_cnt wraps at H_TOTAL-1.
  - v_cnt increments on each h wrap and wraps at V_TOTAL-1.
- hsync is at level HS_POL while h_cnt < H_SYNC, otherwise ~HS_POL. vsync is at level VS_POL while v_cnt < V_SYNC, otherwise ~VS_POL.
- de is high iff h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and v_cnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
- Pixel coordinates within the active area: x = h_cnt-(H_SYNC+H_BACK), y = v_cnt-(V_SYNC+V_BACK).
- Mode and solid colour are shadowed. mode_in and solid_rgb are captured on reset release and at each counter wrap to (0,0). A mid-frame change takes effect from the next frame only.
- Pixel sources:
  - Mode 1, colour bars: bar index = x/(H_ACTIVE/8). Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black, with each channel all-ones or 0.
  - Mode 2, grid: all-ones when x%32==0, y%32==0, x==H_ACTIVE-1 or y==V_ACTIVE-1; otherwise 0.
  - Mode 3, solid: the shadowed solid_rgb.
  - Mode 0, external: ext_rgb when ext_valid=1. If ext_valid=0, output R=all-ones, G=0, B=all-ones and set underflow.
- underflow behaviour:
  - Cleared by rst and on the clock in which frame_start is high.
  - Set one clock after a missing-pixel sample.
  - Only checked in mode 0 and only for de pixels.
- When de=0, RGB outputs are 0 and lvds_tx3_DATA still carries live sync levels.

## Timing
- All outputs are registered. The outputs in cycle t+1 reflect the counter values in cycle t.
- frame_start is high in the cycle the outputs reflect counter position (0,0).
- Request handshake:
  - pix_req is high in cycle c, and pix_x/pix_y carry that pixel's coordinates.
  - The pixel appears with de=1 in cycle c+REQ_LEAD.
  - ext_rgb and ext_valid are sampled at the rising edge that ends cycle c+REQ_LEAD-1.
  - pix_req asserts exactly H_ACTIVE contiguous clocks per active line and never crosses a line boundary.
  - When pix_req=0, pix_x and pix_y hold their last value.
- Reset, while rst is high and in the first clock after it:
  - Counters are at (0,0).
  - RGB outputs are 0, de=0, hsync=~HS_POL, vsync=~VS_POL.
  - pix_req=0, pix_x=0, pix_y=0, frame_start=0, underflow=0.
- Reset release: the first clock after rst falls counts (0,0). frame_start is high in the clock after that.
- Mid-frame rst: the same reset state applies immediately, and the timing restarts a clean frame with no partial-line output.

## Test plan
Benches use small timing: H 2/3/16/2 (H_TOTAL=23), V 1/2/4/1 (V_TOTAL=8), REQ_LEAD=2, COLOR_W=8.
- Frame timing:
  - Stimulus: reset, then run 2 frames.
  - Required: frame_start period is 184 clocks; hsync is low for 2 of every 23 clocks; vsync is low for 23 clocks per frame; 64 de clocks per frame.
- Colour bars:
  - Stimulus: mode 1.
  - Required: bars are 2 pixels wide; pixels x=0..1 give FF/FF/FF, x=2..3 give FF/FF/00, x=14..15 give 00/00/00; RGB is 0 when de is low.
- External path:
  - Stimulus: mode 0; ext_rgb = {pix_x, pix_y, 8'h55} presented one cycle after each pix_req; ext_valid=1.
  - Required: each de pixel equals the coordinates requested 2 clocks earlier; underflow stays 0.
- Underflow:
  - Stimulus: drop ext_valid for the one pixel sample of x=5, y=1.
  - Required: that pixel outputs FF/00/FF; underflow rises the next clock, holds, and clears with the next frame_start.
- Mode shadowing:
  - Stimulus: switch mode 1→3 mid-frame with solid_rgb=123456.
  - Required: bars continue to the end of the frame; the next frame is solid 12/34/56.
- Reset mid-frame:
  - Stimulus: assert rst during an active line.
  - Required: all outputs match reset values next clock; frame_start appears 2 clocks after release.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parametrised LVDS panel timing generator with selectable pixel source,
// lead-time pixel request for an upstream frame buffer and sticky underflow flag.
module lcd_timing_gen #(
   parameter int   H_SYNC   = 20,
   parameter int   H_BACK   = 140,
   parameter int   H_ACTIVE = 1024,
   parameter int   H_FRONT  = 160,
   parameter int   V_SYNC   = 3,
   parameter int   V_BACK   = 20,
   parameter int   V_ACTIVE = 600,
   parameter int   V_FRONT  = 12,
   parameter int   COLOR_W  = 8,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   REQ_LEAD = 2
) (
   input  logic                   lvds_parallel_clk,
   input  logic                   rst,
   input  logic [1:0]             mode_in,
   input  logic [3*COLOR_W-1:0]   solid_rgb,
   input  logic [3*COLOR_W-1:0]   ext_rgb,
   input  logic                   ext_valid,
   output logic                   pix_req,
   output logic [11:0]            pix_x,
   output logic [11:0]            pix_y,
   output logic                   frame_start,
   output logic                   underflow,
   output logic [COLOR_W-1:0]     lvds_tx0_DATA,
   output logic [COLOR_W-1:0]     lvds_tx1_DATA,
   output logic [COLOR_W-1:0]     lvds_tx2_DATA,
   output logic [7:0]             lvds_tx3_DATA
);
   localparam int RGB_W = 3 * COLOR_W;
   localparam logic [11:0] H_LAST = 12'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
   localparam logic [11:0] V_LAST = 12'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
   localparam logic [11:0] H_SY   = 12'(H_SYNC);
   localparam logic [11:0] V_SY   = 12'(V_SYNC);
   localparam logic [11:0] H_A0   = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] H_A1   = 12'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [11:0] V_A0   = 12'(V_SYNC + V_BACK);
   localparam logic [11:0] V_A1   = 12'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [11:0] BAR_W  = 12'(H_ACTIVE / 8);
   localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
   localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);
   localparam logic [11:0] LEAD   = 12'(REQ_LEAD);
   localparam logic [COLOR_W-1:0] ONES = '1;

   logic [11:0]      r_h, r_v, r_px, r_py;
   logic [1:0]       r_mode;
   logic [RGB_W-1:0] r_solid, r_rgb;
   logic             r_de, r_hs, r_vs, r_fs, r_miss, r_under, r_req;

   logic [11:0]      w_x, w_y, w_hr;
   logic [2:0]       w_bar;
   logic             w_h_last, w_v_last, w_origin, w_v_act, w_de, w_req, w_grid, w_miss;
   logic [RGB_W-1:0] w_bars, w_ext, w_pix;

   assign w_h_last = r_h == H_LAST;
   assign w_v_last = r_v == V_LAST;
   assign w_origin = r_h == 12'd0 && r_v == 12'd0;
   assign w_v_act  = r_v >= V_A0 && r_v < V_A1;
   assign w_de     = r_h >= H_A0 && r_h < H_A1 && w_v_act;
   assign w_x      = r_h - H_A0;
   assign w_y      = r_v - V_A0;
   // the lead is shorter than sync+back porch, so a 12-bit wrap never lands in the active span
   assign w_hr     = r_h + LEAD;
   assign w_req    = w_hr >= H_A0 && w_hr < H_A1 && w_v_act;
   assign w_bar    = 3'(w_x / BAR_W);
   assign w_bars   = {{COLOR_W{~w_bar[1]}}, {COLOR_W{~w_bar[2]}}, {COLOR_W{~w_bar[0]}}};
   assign w_grid   = w_x[4:0] == 5'd0 || w_y[4:0] == 5'd0 || w_x == X_LAST || w_y == Y_LAST;
   assign w_ext    = ext_valid ? ext_rgb : {ONES, {COLOR_W{1'b0}}, ONES};
   assign w_pix    = !w_de           ? '0 :
                     r_mode == 2'd1  ? w_bars :
                     r_mode == 2'd2  ? {RGB_W{w_grid}} :
                     r_mode == 2'd3  ? r_solid : w_ext;
   assign w_miss   = w_de && r_mode == 2'd0 && !ext_valid;

   always_ff @(posedge lvds_parallel_clk) begin
      if (rst) begin
         r_h     <= '0;
         r_v     <= '0;
         r_mode  <= mode_in;
         r_solid <= solid_rgb;
         r_rgb   <= '0;
         r_de    <= 1'b0;
         r_hs    <= ~HS_POL;
         r_vs    <= ~VS_POL;
         r_fs    <= 1'b0;
         r_miss  <= 1'b0;
         r_under <= 1'b0;
         r_req   <= 1'b0;
         r_px    <= '0;
         r_py    <= '0;
      end else begin
         r_h <= w_h_last ? '0 : r_h + 12'd1;
         if (w_h_last) r_v <= w_v_last ? '0 : r_v + 12'd1;
         if (w_origin) begin
            r_mode  <= mode_in;
            r_solid <= solid_rgb;
         end
         r_rgb   <= w_pix;
         r_de    <= w_de;
         r_hs    <= r_h < H_SY ? HS_POL : ~HS_POL;
         r_vs    <= r_v < V_SY ? VS_POL : ~VS_POL;
         r_fs    <= w_origin;
         r_miss  <= w_miss;
         r_under <= !w_origin && (r_under || r_miss);
         r_req   <= w_req;
         if (w_req) begin
            r_px <= w_hr - H_A0;
            r_py <= w_y;
         end
      end
   end

   assign pix_req       = r_req;
   assign pix_x         = r_px;
   assign pix_y         = r_py;
   assign frame_start   = r_fs;
   assign underflow     = r_under;
   assign lvds_tx0_DATA = r_rgb[3*COLOR_W-1:2*COLOR_W];
   assign lvds_tx1_DATA = r_rgb[2*COLOR_W-1:COLOR_W];
   assign lvds_tx2_DATA = r_rgb[COLOR_W-1:0];
   assign lvds_tx3_DATA = {5'b0, r_de, r_hs, r_vs};
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: randomized bench for lcd_timing_gen against a frame-position reference model.
module tb_lcd_timing_gen;
   localparam int HS = 2, HB = 3, HA = 16, HF = 2, VS = 1, VB = 2, VA = 4, VF = 1, L = 2;
   localparam int HT = HS + HB + HA + HF, VT = VS + VB + VA + VF, FT = HT * VT;
   localparam logic [58:0] RST_VAL = {24'h0, 8'h03, 1'b0, 24'h0, 2'b00};

   logic clk = 1'b0, rst = 1'b1, ext_valid = 1'b1;
   logic [1:0] mode_in = 2'd1;
   logic [23:0] solid_rgb = 24'h0, ext_rgb = 24'h0;
   logic pix_req, frame_start, underflow;
   logic [11:0] pix_x, pix_y;
   logic [7:0] tx0, tx1, tx2, tx3;

   lcd_timing_gen #(.H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
                    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
                    .COLOR_W(8), .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(L)) dut (
      .lvds_parallel_clk(clk), .rst(rst), .mode_in(mode_in), .solid_rgb(solid_rgb),
      .ext_rgb(ext_rgb), .ext_valid(ext_valid), .pix_req(pix_req), .pix_x(pix_x),
      .pix_y(pix_y), .frame_start(frame_start), .underflow(underflow),
      .lvds_tx0_DATA(tx0), .lvds_tx1_DATA(tx1), .lvds_tx2_DATA(tx2), .lvds_tx3_DATA(tx3));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   logic [23:0] bars [8];

   // reference model: expected outputs from the position of the clock count within the frame
   int k, p, h, v, q, mk, miss_k, e_x, e_y;
   logic [1:0] m_mode;
   logic [23:0] m_solid, e_rgb;
   logic e_de, e_hs, e_vs, e_fs, e_req, e_under;
   logic [11:0] e_px, e_py;

   function automatic bit in_de(int pos);
      int hh = pos % HT, vv = pos / HT;
      return hh >= HS + HB && hh < HS + HB + HA && vv >= VS + VB && vv < VS + VB + VA;
   endfunction

   function automatic logic [23:0] src(logic [1:0] m, int x, int y, logic [23:0] s,
                                       logic [23:0] er, logic ev);
      int b = x / (HA / 8);
      bit r = (b == 0 || b == 1 || b == 4 || b == 5), g = b < 4, bl = (b % 2) == 0;
      bit line = (x % 32 == 0) || (y % 32 == 0) || x == HA - 1 || y == VA - 1;
      if (m == 2'd1) return {{8{r}}, {8{g}}, {8{bl}}};
      if (m == 2'd2) return line ? 24'hFFFFFF : 24'h0;
      if (m == 2'd3) return s;
      return ev ? er : 24'hFF00FF;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         k <= 0; miss_k <= -1; m_mode <= mode_in; m_solid <= solid_rgb;
         e_rgb <= 24'h0; e_de <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b1; e_fs <= 1'b0;
         e_req <= 1'b0; e_under <= 1'b0; e_px <= 12'h0; e_py <= 12'h0;
      end else begin
         p = k % FT; h = p % HT; v = p / HT; q = (k + L) % FT;
         mk = (p == 0) ? -1 : miss_k;
         if (in_de(p) && m_mode == 2'd0 && !ext_valid && mk < 0) mk = k;
         k <= k + 1;
         miss_k <= mk;
         e_under <= mk >= 0 && k + 1 >= mk + 2;
         e_hs <= h >= HS; e_vs <= v >= VS; e_de <= in_de(p); e_fs <= p == 0;
         e_x <= h - HS - HB; e_y <= v - VS - VB;
         e_rgb <= in_de(p) ? src(m_mode, h - HS - HB, v - VS - VB, m_solid, ext_rgb, ext_valid) : 24'h0;
         e_req <= in_de(q);
         if (in_de(q)) begin
            e_px <= 12'(q % HT - HS - HB);
            e_py <= 12'(q / HT - VS - VB);
         end
         if (p == 0) begin
            m_mode <= mode_in;
            m_solid <= solid_rgb;
         end
      end
   end

   logic [58:0] w_got, w_exp;
   assign w_got = {tx0, tx1, tx2, tx3, pix_req, pix_x, pix_y, frame_start, underflow};
   assign w_exp = {e_rgb, 5'b0, e_de, e_hs, e_vs, e_req, e_px, e_py, e_fs, e_under};

   // upstream source: answers each request one cycle later, optionally withholding a pixel
   logic [23:0] nxt_rgb = 24'h0;
   logic nxt_valid = 1'b1, drop_en = 1'b0, rnd_drop = 1'b0;

   task automatic step();
      @(negedge clk);
      cyc++;
      ext_rgb = nxt_rgb;
      ext_valid = nxt_valid;
      nxt_rgb = {pix_x[7:0], pix_y[7:0], 8'h55};
      nxt_valid = !(pix_req && ((drop_en && pix_x == 12'd5 && pix_y == 12'd1) ||
                                (rnd_drop && $urandom_range(9) == 0)));
   endtask

   task automatic test_reset();
      repeat (3) step();
      if (w_got !== RST_VAL) begin n_bad++; $display("FAIL reset_hold: got %h expected %h", w_got, RST_VAL); end
      n_cmp++;
      rst = 1'b0;
      if (w_got !== RST_VAL) begin n_bad++; $display("FAIL reset_first: got %h expected %h", w_got, RST_VAL); end
      n_cmp++;
      step();
      if (frame_start !== 1'b1) begin n_bad++; $display("FAIL reset_fs: got %b expected 1", frame_start); end
      n_cmp++;
   endtask

   task automatic test_frame_timing();
      int n_fs = 0, n_hs = 0, n_vs = 0, n_de = 0, fs0 = -1, gap = -1;
      for (int i = 0; i < 2 * FT; i++) begin
         if (i > 0) step();
         if (w_got !== w_exp) begin n_bad++; $display("FAIL timing_model @%0d: got %h expected %h", cyc, w_got, w_exp); end
         n_cmp++;
         if (frame_start) begin
            if (fs0 >= 0 && gap < 0) gap = i - fs0;
            if (fs0 < 0) fs0 = i;
            n_fs++;
         end
         n_hs += int'(!tx3[1]);
         n_vs += int'(!tx3[0]);
         n_de += int'(tx3[2]);
      end
      if (gap !== FT) begin n_bad++; $display("FAIL fs_period: got %0d expected %0d", gap, FT); end
      if (n_fs !== 2) begin n_bad++; $display("FAIL fs_count: got %0d expected 2", n_fs); end
      if (n_hs !== 2 * HS * VT) begin n_bad++; $display("FAIL hsync_low: got %0d expected %0d", n_hs, 2 * HS * VT); end
      if (n_vs !== 2 * HT) begin n_bad++; $display("FAIL vsync_low: got %0d expected %0d", n_vs, 2 * HT); end
      if (n_de !== 128) begin n_bad++; $display("FAIL de_count: got %0d expected 128", n_de); end
      n_cmp += 5;
   endtask

   task automatic test_colour_bars();
      int x = 0;
      for (int i = 0; i < FT; i++) begin
         step();
         if (w_got !== w_exp) begin n_bad++; $display("FAIL bars_model @%0d: got %h expected %h", cyc, w_got, w_exp); end
         n_cmp++;
         if (tx3[2]) begin
            if (x == 0 || x == 1) begin
               if ({tx0, tx1, tx2} !== 24'hFFFFFF) begin n_bad++; $display("FAIL bar_white x=%0d: got %h expected ffffff", x, {tx0, tx1, tx2}); end
               n_cmp++;
            end
            if (x == 2 || x == 3) begin
               if ({tx0, tx1, tx2} !== 24'hFFFF00) begin n_bad++; $display("FAIL bar_yellow x=%0d: got %h expected ffff00", x, {tx0, tx1, tx2}); end
               n_cmp++;
            end
            if (x == 14 || x == 15) begin
               if ({tx0, tx1, tx2} !== 24'h000000) begin n_bad++; $display("FAIL bar_black x=%0d: got %h expected 000000", x, {tx0, tx1, tx2}); end
               n_cmp++;
            end
            x++;
         end else begin
            x = 0;
            if ({tx0, tx1, tx2} !== 24'h0) begin n_bad++; $display("FAIL blank_rgb @%0d: got %h expected 0", cyc, {tx0, tx1, tx2}); end
            n_cmp++;
         end
      end
   endtask

   task automatic test_external();
      bit seen = 0;
      mode_in = 2'd0;
      for (int i = 0; i <= FT && !seen; i++) begin
         step();
         seen = frame_start;
      end
      if (!seen) begin n_bad++; $display("FAIL ext_sync: got no frame_start expected one within %0d", FT); end
      n_cmp++;
      for (int i = 1; i < FT; i++) begin
         step();
         if (w_got !== w_exp) begin n_bad++; $display("FAIL ext_model @%0d: got %h expected %h", cyc, w_got, w_exp); end
         if (tx3[2] && {tx0, tx1, tx2} !== {8'(e_x), 8'(e_y), 8'h55}) begin
            n_bad++; $display("FAIL ext_pixel: got %h expected %h", {tx0, tx1, tx2}, {8'(e_x), 8'(e_y), 8'h55});
         end
         if (underflow !== 1'b0) begin n_bad++; $display("FAIL ext_underflow: got %b expected 0", underflow); end
         n_cmp += 3;
      end
   endtask

   task automatic test_underflow();
      int saw = -1;
      bit done = 0;
      drop_en = 1'b1;
      for (int i = 0; i < 2 * FT && !done; i++) begin
         step();
         if (w_got !== w_exp) begin n_bad++; $display("FAIL uf_model @%0d: got %h expected %h", cyc, w_got, w_exp); end
         n_cmp++;
         if (saw >= 0 && i == saw + 1) begin
            if (underflow !== 1'b1) begin n_bad++; $display("FAIL uf_rise: got %b expected 1", underflow); end
            n_cmp++;
         end
         if (saw >= 0 && frame_start) begin
            if (underflow !== 1'b0) begin n_bad++; $display("FAIL uf_clear: got %b expected 0", underflow); end
            n_cmp++;
            done = 1;
         end
         if (tx3[2] && e_x == 5 && e_y == 1 && saw < 0) begin
            if ({tx0, tx1, tx2} !== 24'hFF00FF) begin n_bad++; $display("FAIL uf_pixel: got %h expected ff00ff", {tx0, tx1, tx2}); end
            n_cmp++;
            saw = i;
            drop_en = 1'b0;
         end
      end
      drop_en = 1'b0;
      if (!done) begin n_bad++; $display("FAIL uf_timeout: got no clear expected clear at frame_start"); end
      n_cmp++;
   endtask

   task automatic test_shadow();
      bit seen = 0;
      mode_in = 2'd1;
      for (int i = 0; i <= FT && !seen; i++) begin step(); seen = frame_start; end
      repeat (90) step();
      mode_in = 2'd3;
      solid_rgb = 24'h123456;
      seen = 0;
      for (int i = 0; i <= FT && !seen; i++) begin
         step();
         seen = frame_start;
         if (w_got !== w_exp) begin n_bad++; $display("FAIL shadow_model @%0d: got %h expected %h", cyc, w_got, w_exp); end
         n_cmp++;
         if (tx3[2]) begin
            if ({tx0, tx1, tx2} !== bars[e_x / 2]) begin n_bad++; $display("FAIL shadow_bars x=%0d: got %h expected %h", e_x, {tx0, tx1, tx2}, bars[e_x / 2]); end
            n_cmp++;
         end
      end
      for (int i = 1; i < FT; i++) begin
         step();
         if (tx3[2]) begin
            if ({tx0, tx1, tx2} !== 24'h123456) begin n_bad++; $display("FAIL shadow_solid: got %h expected 123456", {tx0, tx1, tx2}); end
            n_cmp++;
         end
      end
   endtask

   task automatic test_random();
      rnd_drop = 1'b1;
      for (int i = 0; i < 4 * FT; i++) begin
         if ($urandom_range(99) == 0) begin
            mode_in = 2'($urandom_range(3));
            solid_rgb = 24'($urandom);
         end
         step();
         if (w_got !== w_exp) begin n_bad++; $display("FAIL random_model @%0d: got %h expected %h", cyc, w_got, w_exp); end
         n_cmp++;
      end
      rnd_drop = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      mode_in = 2'd1;
      for (int i = 0; i <= FT && !seen; i++) begin step(); seen = tx3[2]; end
      rst = 1'b1;
      step();
      if (w_got !== RST_VAL) begin n_bad++; $display("FAIL midrst_now: got %h expected %h", w_got, RST_VAL); end
      step();
      if (w_got !== RST_VAL) begin n_bad++; $display("FAIL midrst_hold: got %h expected %h", w_got, RST_VAL); end
      rst = 1'b0;
      if (w_got !== RST_VAL) begin n_bad++; $display("FAIL midrst_first: got %h expected %h", w_got, RST_VAL); end
      n_cmp += 3;
      step();
      if (frame_start !== 1'b1) begin n_bad++; $display("FAIL midrst_fs: got %b expected 1", frame_start); end
      if (w_got !== w_exp) begin n_bad++; $display("FAIL midrst_model: got %h expected %h", w_got, w_exp); end
      n_cmp += 2;
      for (int i = 0; i < FT; i++) begin
         step();
         if (w_got !== w_exp) begin n_bad++; $display("FAIL midrst_frame @%0d: got %h expected %h", cyc, w_got, w_exp); end
         n_cmp++;
      end
   endtask

   initial begin
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      test_reset();
      test_frame_timing();
      test_colour_bars();
      test_external();
      test_underflow();
      test_shadow();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
